cache_ram_arbiter: RTL and testbench
====================================

// Module: cache_ram_arbiter
// PURPOSE
//  Shares the cache tag/state/data RAM between the downstream L1 request FSM (CD side, CDREQ_*) and the
//  upstream snoop FSM (SU side, SUREQ_*). Grants one owner at a time and holds per-side set locks across
//  multi-phase transactions, so neither side touches a set the other side has in flight.
//  Snoops normally win; a starvation counter guarantees CD progress.
// PARAMETERS
//  IDX_W     6  set-index width compared for lock conflicts
//  MAX_WAIT  8  cycles CD may wait with cd_req high before it overrides SU priority
//  (localparam CNT_W = $clog2(MAX_WAIT+1))
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  cd_req      in   1      CD side requests RAM; held high until cd_gnt
//  cd_idx      in   IDX_W  CD set index; stable while cd_req high
//  cd_done     in   1      1-cycle pulse: CD finished with RAM (valid only while cd_gnt)
//  cd_hold     in   1      sampled with cd_done: keep set lock on cd_idx after release
//  cd_unlock   in   1      1-cycle pulse: clear CD set lock
//  cd_gnt      out  1      CD owns RAM
//  cd_stall    out  1      cd_req blocked by SU set lock
//  su_req / su_idx / su_done / su_hold / su_unlock / su_gnt / su_stall: same as CD, for SU side
//  ram_sel     out  1      RAM mux select: 0=CD, 1=SU (holds last owner when idle)
//  ram_busy    out  1      one side owns RAM
// BEHAVIOUR
//  Reset: all outputs 0; FSM ARB_IDLE; locks clear; wait counter 0. Reset mid-grant drops gnt at once.
//  FSM (2-bit, registered):
//   ARB_IDLE    -> ARB_GNT_CD / ARB_GNT_SU per eligibility/priority below; else stay.
//   ARB_GNT_CD  -> ARB_IDLE on cd_done. ARB_GNT_SU -> ARB_IDLE on su_done.
//  Timing: req eligible in ARB_IDLE at cycle N -> gnt high from N+1. done at cycle M -> gnt low at M+1.
//   Earliest next grant is M+2 (one idle bubble). done while not granted is ignored.
//  Eligibility: X eligible = X_req && !(other_lock_vld && other_lock_idx == X_idx).
//   X_stall = X_req && lock-conflict (combinational, registered locks). Own lock never blocks own side.
//  Priority when both eligible: SU, unless cd_wait_cnt == MAX_WAIT -> CD.
//  cd_wait_cnt: +1 each cycle cd_req && !cd_gnt, saturates at MAX_WAIT; cleared when cd_gnt asserts
//   and when cd_req low.
//  Set locks (per side): on X_done with X_hold=1 -> lock_vld=1, lock_idx=X_idx captured at grant.
//   X_unlock clears lock_vld next cycle; eligibility sees the clear one cycle after the pulse.
//   done+hold with unlock in same cycle: unlock ignored (lock set). New done+hold overwrites lock_idx.
//  Lock state is independent of FSM: a side may hold a lock while the RAM is granted to the other side.
//  Deadlock rule: a side holding a lock does not request a set locked by the other (checked by
//   assertion, not resolved in RTL).
//  ram_sel/ram_busy/gnt are registered outputs decoded from the FSM; cd_gnt and su_gnt are never both high.
// STRUCTURE
//  cache_pkg additions: ARB_IDLE=2'b00, ARB_GNT_CD=2'b01, ARB_GNT_SU=2'b10; ARB_SEL_CD=1'b0, ARB_SEL_SU=1'b1.
//  Sub-module cache_set_lock (lock_vld/lock_idx register, capture on done&hold, clear on unlock, conflict
//   compare output), instantiated once per side. FSM, priority and wait counter in the top.
// TESTING
//  1 Lone cd_req=1 idx=5 at cycle 2 -> cd_gnt=1,ram_sel=0 at 3; cd_done at 6 -> cd_gnt=0 at 7; ram_busy tracks.
//  2 cd_req and su_req together, idx 3/9, cnt 0 -> su_gnt first; after su_done, cd_gnt two cycles later.
//  3 su_req held continuously with back-to-back grants, cd_req high -> cd_gnt no later than after
//    MAX_WAIT=8 wait cycles; counter clears on grant.
//  4 CD done with hold=1 idx=12; su_req idx=12 -> su_stall=1, no su_gnt; cd_unlock pulse at T
//    -> su_stall=0 at T+1, su_gnt at T+2. su_req idx=13 during lock -> granted normally.
//  5 Same-cycle done+hold+unlock -> lock remains set; done without grant -> no state change.
//  6 rst asserted asynchronously during ARB_GNT_SU with CD lock held -> su_gnt=0, locks clear, counter 0
//    immediately; first cycle after release behaves as scenario 1.
//  Always-on assertions: !(cd_gnt&&su_gnt); gnt only after req; req/idx stable until gnt.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache RAM arbiter: FSM state encoding and RAM mux select values.
package cache_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_GNT_CD = 2'b01,
      ARB_GNT_SU = 2'b10
   } arb_state_e;

   localparam logic ARB_SEL_CD = 1'b0;
   localparam logic ARB_SEL_SU = 1'b1;

endpackage

// File: rtl/cache_set_lock.sv
// Per-side set lock: remembers the set index granted, locks it on done+hold, clears on unlock,
// and reports whether the other side's requested index collides with the held lock.
module cache_set_lock #(
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] req_idx,
   input  logic             done,
   input  logic             hold,
   input  logic             unlock,
   input  logic [IDX_W-1:0] cmp_idx,
   output logic             lock_vld,
   output logic             conflict
);

   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
   logic             lock_vld_q, lock_vld_d;

   // The lock uses the index seen at grant time; the requester may change idx once granted.
   always_comb begin
      gnt_idx_d  = start ? req_idx : gnt_idx_q;
      lock_vld_d = lock_vld_q;
      lock_idx_d = lock_idx_q;
      if (done && hold) begin
         lock_vld_d = 1'b1;
         lock_idx_d = gnt_idx_q;
      end else if (unlock) begin
         lock_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_idx_q  <= '0;
         lock_idx_q <= '0;
         lock_vld_q <= 1'b0;
      end else begin
         gnt_idx_q  <= gnt_idx_d;
         lock_idx_q <= lock_idx_d;
         lock_vld_q <= lock_vld_d;
      end
   end

   assign lock_vld = lock_vld_q;
   assign conflict = lock_vld_q && (lock_idx_q == cmp_idx);

endmodule

// File: rtl/cache_ram_arbiter.sv
// Arbitrates the cache RAM between the CD request side and the SU snoop side, with snoop priority,
// a CD starvation counter and per-side set locks that span multi-phase transactions.
module cache_ram_arbiter
   import cache_pkg::*;
#(
   parameter int IDX_W    = 6,
   parameter int MAX_WAIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cd_req,
   input  logic [IDX_W-1:0] cd_idx,
   input  logic             cd_done,
   input  logic             cd_hold,
   input  logic             cd_unlock,
   output logic             cd_gnt,
   output logic             cd_stall,
   input  logic             su_req,
   input  logic [IDX_W-1:0] su_idx,
   input  logic             su_done,
   input  logic             su_hold,
   input  logic             su_unlock,
   output logic             su_gnt,
   output logic             su_stall,
   output logic             ram_sel,
   output logic             ram_busy
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   arb_state_e       state_q, state_d;
   logic             sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cd_start, su_start;
   logic             cd_done_v, su_done_v;
   logic             cd_blocked, su_blocked;
   logic             cd_lock_vld, su_lock_vld;
   logic             cd_elig, su_elig;

   // A done pulse only counts while that side actually owns the RAM.
   assign cd_done_v = cd_done && (state_q == ARB_GNT_CD);
   assign su_done_v = su_done && (state_q == ARB_GNT_SU);

   cache_set_lock #(.IDX_W(IDX_W)) u_cd_lock (
      .clk      (clk),
      .rst      (rst),
      .start    (cd_start),
      .req_idx  (cd_idx),
      .done     (cd_done_v),
      .hold     (cd_hold),
      .unlock   (cd_unlock),
      .cmp_idx  (su_idx),
      .lock_vld (cd_lock_vld),
      .conflict (su_blocked)
   );

   cache_set_lock #(.IDX_W(IDX_W)) u_su_lock (
      .clk      (clk),
      .rst      (rst),
      .start    (su_start),
      .req_idx  (su_idx),
      .done     (su_done_v),
      .hold     (su_hold),
      .unlock   (su_unlock),
      .cmp_idx  (cd_idx),
      .lock_vld (su_lock_vld),
      .conflict (cd_blocked)
   );

   assign cd_stall = cd_req && cd_blocked;
   assign su_stall = su_req && su_blocked;
   assign cd_elig  = cd_req && !cd_blocked;
   assign su_elig  = su_req && !su_blocked;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cd_start = 1'b0;
      su_start = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            // Snoops win ties unless CD has waited the full starvation budget.
            if (cd_elig && (!su_elig || cnt_q == CNT_MAX)) begin
               state_d  = ARB_GNT_CD;
               sel_d    = ARB_SEL_CD;
               cd_start = 1'b1;
            end else if (su_elig) begin
               state_d  = ARB_GNT_SU;
               sel_d    = ARB_SEL_SU;
               su_start = 1'b1;
            end
         end
         ARB_GNT_CD: if (cd_done) state_d = ARB_IDLE;
         ARB_GNT_SU: if (su_done) state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!cd_req || cd_start || state_q == ARB_GNT_CD) cnt_d = '0;
      else if (cnt_q != CNT_MAX)                        cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         sel_q   <= ARB_SEL_CD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cd_gnt   = (state_q == ARB_GNT_CD);
   assign su_gnt   = (state_q == ARB_GNT_SU);
   assign ram_busy = (state_q != ARB_IDLE);
   assign ram_sel  = sel_q;

   a_gnt_excl: assert property (@(posedge clk) disable iff (rst) !(cd_gnt && su_gnt));
   a_cd_gnt_req: assert property (@(posedge clk) disable iff (rst) $rose(cd_gnt) |-> $past(cd_req));
   a_su_gnt_req: assert property (@(posedge clk) disable iff (rst) $rose(su_gnt) |-> $past(su_req));
   a_cd_stable: assert property (@(posedge clk) disable iff (rst)
      cd_req && !cd_gnt |=> cd_gnt || (cd_req && $stable(cd_idx)));
   a_su_stable: assert property (@(posedge clk) disable iff (rst)
      su_req && !su_gnt |=> su_gnt || (su_req && $stable(su_idx)));
   // A side that holds a lock must never wait on the other side's lock.
   a_cd_no_deadlock: assert property (@(posedge clk) disable iff (rst) !(cd_lock_vld && cd_stall));
   a_su_no_deadlock: assert property (@(posedge clk) disable iff (rst) !(su_lock_vld && su_stall));

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Bench for cache_ram_arbiter: per-cycle vector table scored through an expected queue,
// plus directed starvation and asynchronous-reset sequences.
module tb_cache_ram_arbiter;

   localparam int IDX_W = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             cd_req, cd_done, cd_hold, cd_unlock;
   logic [IDX_W-1:0] cd_idx;
   logic             su_req, su_done, su_hold, su_unlock;
   logic [IDX_W-1:0] su_idx;
   logic             cd_gnt, cd_stall, su_gnt, su_stall, ram_sel, ram_busy;

   int total = 0;
   int bad   = 0;

   // Expected outputs packed as {cd_gnt, su_gnt, ram_sel, ram_busy, cd_stall, su_stall}.
   typedef struct {
      logic             cr;
      logic [IDX_W-1:0] ci;
      logic             cdn, ch, cu;
      logic             sr;
      logic [IDX_W-1:0] si;
      logic             sdn, sh, su;
      logic [5:0]       exp;
   } vec_t;

   vec_t       rows[$];
   logic [5:0] exp_q[$];

   cache_ram_arbiter #(.IDX_W(IDX_W), .MAX_WAIT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cd_req    (cd_req),
      .cd_idx    (cd_idx),
      .cd_done   (cd_done),
      .cd_hold   (cd_hold),
      .cd_unlock (cd_unlock),
      .cd_gnt    (cd_gnt),
      .cd_stall  (cd_stall),
      .su_req    (su_req),
      .su_idx    (su_idx),
      .su_done   (su_done),
      .su_hold   (su_hold),
      .su_unlock (su_unlock),
      .su_gnt    (su_gnt),
      .su_stall  (su_stall),
      .ram_sel   (ram_sel),
      .ram_busy  (ram_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [5:0] outs();
      return {cd_gnt, su_gnt, ram_sel, ram_busy, cd_stall, su_stall};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cd_req = 0; cd_idx = '0; cd_done = 0; cd_hold = 0; cd_unlock = 0;
      su_req = 0; su_idx = '0; su_done = 0; su_hold = 0; su_unlock = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic row(input logic cr, input int ci, input logic cdn, input logic ch, input logic cu,
                      input logic sr, input int si, input logic sdn, input logic sh, input logic su,
                      input logic [5:0] exp);
      vec_t v;
      v.cr = cr; v.ci = IDX_W'(ci); v.cdn = cdn; v.ch = ch; v.cu = cu;
      v.sr = sr; v.si = IDX_W'(si); v.sdn = sdn; v.sh = sh; v.su = su;
      v.exp = exp;
      rows.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      cd_req = v.cr; cd_idx = v.ci; cd_done = v.cdn; cd_hold = v.ch; cd_unlock = v.cu;
      su_req = v.sr; su_idx = v.si; su_done = v.sdn; su_hold = v.sh; su_unlock = v.su;
   endtask

   initial begin
      int first_cd;
      int su_grants;
      logic [5:0] got;

      //   cr ci cdn ch cu   sr si sdn sh su   {cg sg sel busy cs ss}
      // lone CD request, idx 5
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b000000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b000000);
      row(1, 5, 0,0,0,  0, 0, 0,0,0,  6'b000000);
      row(0, 5, 0,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 1,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b000000);
      // simultaneous requests: SU first, CD two cycles after su_done
      row(1, 3, 0,0,0,  1, 9, 0,0,0,  6'b000000);
      row(1, 3, 0,0,0,  0, 9, 0,0,0,  6'b011100);
      row(1, 3, 0,0,0,  0, 0, 1,0,0,  6'b011100);
      row(1, 3, 0,0,0,  0, 0, 0,0,0,  6'b001000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 1,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b000000);
      // CD locks set 12 (idx changed before done), SU stalls until unlock
      row(1,12, 0,0,0,  0, 0, 0,0,0,  6'b000000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 1,1,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 0,0,0,  1,12, 0,0,0,  6'b000001);
      row(0, 0, 0,0,0,  1,12, 0,0,0,  6'b000001);
      row(0, 0, 0,0,1,  1,12, 0,0,0,  6'b000001);
      row(0, 0, 0,0,0,  1,12, 0,0,0,  6'b000000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b011100);
      row(0, 0, 0,0,0,  0, 0, 1,0,0,  6'b011100);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b001000);
      // done+hold+unlock together keeps the lock; other set 13 granted meanwhile
      row(1,12, 0,0,0,  0, 0, 0,0,0,  6'b001000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 1,1,1,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 0,0,0,  1,13, 0,0,0,  6'b000000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b011100);
      row(0, 0, 0,0,0,  0, 0, 1,0,0,  6'b011100);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b001000);
      row(0, 0, 0,0,0,  1,12, 0,0,0,  6'b001001);
      row(0, 0, 1,1,0,  1,12, 0,0,0,  6'b001001);
      row(0, 0, 0,0,1,  1,12, 0,0,0,  6'b001001);
      row(0, 0, 0,0,0,  1,12, 0,0,0,  6'b001000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b011100);
      row(0, 0, 0,0,0,  0, 0, 1,0,0,  6'b011100);
      // done+hold while not granted must not create a lock
      row(0, 0, 1,1,0,  0, 0, 0,0,0,  6'b001000);
      row(0, 0, 0,0,0,  1,12, 0,0,0,  6'b001000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b011100);
      row(0, 0, 0,0,0,  0, 0, 1,0,0,  6'b011100);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b001000);
      // SU locks set 7, CD stalls until su_unlock
      row(0, 0, 0,0,0,  1, 7, 0,0,0,  6'b001000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b011100);
      row(0, 0, 0,0,0,  0, 0, 1,1,0,  6'b011100);
      row(1, 7, 0,0,0,  0, 0, 0,0,0,  6'b001010);
      row(1, 7, 0,0,0,  0, 0, 0,0,1,  6'b001010);
      row(1, 7, 0,0,0,  0, 0, 0,0,0,  6'b001000);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 1,0,0,  0, 0, 0,0,0,  6'b100100);
      row(0, 0, 0,0,0,  0, 0, 0,0,0,  6'b000000);

      // reset
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outs", 32'(outs()), 32'h0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_outs", 32'(outs()), 32'h0);

      foreach (rows[i]) begin
         step();
         drive(rows[i]);
         exp_q.push_back(rows[i].exp);
         @(negedge clk);
         got = outs();
         check($sformatf("row%0d", i), 32'(got), 32'(exp_q.pop_front()));
      end

      // starvation: SU re-requests back to back, CD must win once the counter saturates
      first_cd  = -1;
      su_grants = 0;
      for (int k = 0; k < 30 && first_cd < 0; k++) begin
         step();
         cd_done = 1'b0;
         su_done = su_gnt;
         su_req  = 1'b1; su_idx = 6'd2;
         cd_req  = 1'b1; cd_idx = 6'd1;
         if (su_gnt) su_grants++;
         if (cd_gnt) begin
            first_cd = k;
            cd_req   = 1'b0;
            cd_done  = 1'b1;
            @(negedge clk);
            check("starve_cnt_cleared", 32'(dut.cnt_q), 32'd0);
         end
      end
      check("starve_cd_gnt_cycle", 32'(first_cd), 32'd9);
      check("starve_su_grants", 32'(su_grants), 32'd4);
      step();
      cd_done = 1'b0; su_done = 1'b0;
      step();
      check("starve_su_regrant", 32'(su_gnt), 32'd1);
      su_req = 1'b0; su_done = 1'b1;
      step();
      idle_inputs();

      // async reset during an SU grant while CD holds a lock and CD is waiting
      step();
      cd_req = 1'b1; cd_idx = 6'd20;
      step();
      cd_req = 1'b0;
      step();
      cd_done = 1'b1; cd_hold = 1'b1;
      step();
      cd_done = 1'b0; cd_hold = 1'b0;
      su_req = 1'b1; su_idx = 6'd21;
      cd_req = 1'b1; cd_idx = 6'd30;
      step();
      su_req = 1'b0;
      step();
      check("rst_pre_su_gnt", 32'(su_gnt), 32'd1);
      check("rst_pre_cd_lock", 32'(dut.u_cd_lock.lock_vld_q), 32'd1);
      #2;
      rst = 1'b1;
      idle_inputs();
      #1;
      check("rst_async_outs", 32'(outs()), 32'h0);
      check("rst_async_cd_lock", 32'(dut.u_cd_lock.lock_vld_q), 32'd0);
      check("rst_async_cnt", 32'(dut.cnt_q), 32'd0);
      step();
      rst = 1'b0;
      step();
      cd_req = 1'b1; cd_idx = 6'd5;
      @(negedge clk);
      check("rst_after_req_cycle", 32'(outs()), 32'h0);
      step();
      cd_req = 1'b0;
      @(negedge clk);
      check("rst_after_gnt_cycle", 32'(outs()), 32'b100100);
      step();
      cd_done = 1'b1;
      su_req = 1'b1; su_idx = 6'd20;
      @(negedge clk);
      check("rst_lock_gone_stall", 32'(su_stall), 32'd0);
      step();
      cd_done = 1'b0;
      step();
      check("rst_lock_gone_gnt", 32'(su_gnt), 32'd1);
      su_req = 1'b0; su_done = 1'b1;
      step();
      idle_inputs();
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
